data_mem: RTL and testbench
===========================

# data_mem

Word-organised data memory that acts as the responder for the load/store requests issued by the single-cycle datapath. The ALU result supplies the byte address, busB supplies the store data, and funct3 supplies the access type. The block performs byte, halfword or word stores with lane enables, and loads with sign or zero extension. It also reports misaligned, out-of-range and reserved accesses. Each request gets exactly one response pulse, and only one request is outstanding at a time.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; a power of two, at least 4.
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- MemOp  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; all other codes are reserved.
- Addr  in  32  byte address, little-endian.
- DataIn  in  32  store data; stores use the low byte or low halfword as needed.
- rsp_valid  out  1  one-cycle response pulse.
- DataOut  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  out  1  qualified by rsp_valid; set on misaligned, out-of-range or reserved access.

## Operation
- States: IDLE and RESP.
  - req_ready = 1 only in IDLE.
  - Accept = req_valid & req_ready, sampled at the rising edge of Clk.
  - IDLE goes to RESP on accept; RESP always goes to IDLE on the next edge.
- Word index = Addr[31:2]. Lane = Addr[1:0].
- Error conditions, all registered at accept:
  - Misaligned: H/HU with Addr[0]=1, or W with Addr[1:0]≠0.
  - Out-of-range: Addr[31:2] ≥ DEPTH_WORDS.
  - Reserved: MemOp is 011, 110 or 111 for a load; for a store, MemOp is anything other than 000/001/010.
- On an error, the array is not modified, DataOut = 0 and rsp_err = 1.
- Store with no error: the write commits at the accept edge.
  - SB writes byte lane Lane with DataIn[7:0].
  - SH writes lanes {Lane+1, Lane} with DataIn[15:0].
  - SW writes all four lanes.
  - Other lanes keep their value.
- Load with no error: the word is read at the accept edge and the lane select is registered.
  - In RESP, the selected byte or halfword is right-justified.
  - B and H sign-extend from bit 7 or bit 15; BU and HU zero-extend; W passes all 32 bits.
- A load at the same address directly after a store returns the stored data, because the store completed at least one edge earlier.
- Memory contents are not reset; they are undefined until written.
- Reset at any time:
  - state is forced to IDLE; rsp_valid, rsp_err and DataOut become 0; req_ready becomes 1.
  - A pending response is dropped.
  - A store committed before reset stays in memory.
- req_valid asserted while in RESP is ignored; the requester must hold the request until it sees req_ready.

## Timing
- Reset values: req_ready = 1, rsp_valid = 0, rsp_err = 0, DataOut = 0.
- Accept at edge N gives rsp_valid = 1 for the whole cycle between edges N and N+1, with DataOut and rsp_err valid in that same cycle.
- req_ready = 0 in that cycle.
- Earliest next accept is edge N+2. Sustained throughput is one request per 2 cycles.
- rsp_valid is never high for two consecutive cycles.
- All outputs are registered or decoded from state; there is no combinational path from req_* to rsp_*.

## Test plan
- Reset, then SW Addr=0x10 DataIn=0xDEADBEEF, then LW Addr=0x10. Store response: rsp_valid=1, rsp_err=0, DataOut=0. Load response: DataOut=0xDEADBEEF, rsp_err=0.
- After the word at 0x10 holds 0xDEADBEEF:
  - SB Addr=0x11 DataIn=0x000000A5, then LW 0x10 → 0xDEADA5EF.
  - LB 0x11 → 0xFFFFFFA5.
  - LBU 0x11 → 0x000000A5.
  - LH 0x12 → 0xFFFFDEAD.
  - LHU 0x12 → 0x0000DEAD.
- Error cases:
  - LW 0x13 → rsp_err=1, DataOut=0.
  - SH 0x11 DataIn=0x1234 → rsp_err=1; a following LW 0x10 still returns 0xDEADA5EF.
  - MemOp=011 → rsp_err=1.
  - LW at 4·DEPTH_WORDS → rsp_err=1.
- Hold req_valid high continuously with back-to-back requests → req_ready toggles 1,0,1,0. Exactly one rsp_valid pulse per accepted request, each one cycle after its accept.
- Assert Rst during RESP of a load → rsp_valid drops to 0 immediately and req_ready=1. No response is produced for that load after reset is released.
- SW 0x20=0x11223344, reset mid-stream, then LW 0x20 → 0x11223344.

Source files
------------

// File: rtl/data_mem.sv
// Word-organised data memory answering single-cycle datapath loads/stores.
// Supports B/H/W stores with lane enables, sign/zero-extending loads, and error reporting.
module data_mem #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  MemOp,
  input  logic [31:0] Addr,
  input  logic [31:0] DataIn,
  output logic        rsp_valid,
  output logic [31:0] DataOut,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic {IDLE, RESP} state_e;

  state_e      state_q, state_d;
  logic        accept;
  logic        misaligned, out_of_range, reserved, err;
  logic [AW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wdata;

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rd_word_q;
  logic [1:0]  lane_q;
  logic [2:0]  op_q;
  logic        we_q, err_q;

  logic [31:0] word_sh;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // Request decode: error classification and store lane enables.
  always_comb begin
    misaligned   = ((MemOp == 3'b001 || MemOp == 3'b101) && Addr[0]) ||
                   (MemOp == 3'b010 && Addr[1:0] != 2'b00);
    out_of_range = {1'b0, Addr[31:2]} >= 31'(DEPTH_WORDS);
    reserved     = req_we ? (MemOp > 3'b010)
                          : (MemOp == 3'b011 || MemOp[2:1] == 2'b11);
    err          = misaligned | out_of_range | reserved;
    idx          = Addr[AW+1:2];
    be           = 4'hf;
    wdata        = DataIn;
    case (MemOp[1:0])
      2'b00: begin
        be    = 4'b0001 << Addr[1:0];
        wdata = {4{DataIn[7:0]}};
      end
      2'b01: begin
        be    = Addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{DataIn[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_ready = (state_q == IDLE);
    accept    = req_valid & (state_q == IDLE);
    case (state_q)
      IDLE:    if (accept) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      lane_q  <= 2'b00;
      op_q    <= 3'b000;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        lane_q <= Addr[1:0];
        op_q   <= MemOp;
        we_q   <= req_we;
        err_q  <= err;
      end
    end
  end

  // Array is never reset; Rst gating keeps a request seen during reset from committing.
  always_ff @(posedge Clk) begin
    if (accept && !Rst) begin
      if (req_we && !err) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      if (!req_we) rd_word_q <= mem_q[idx];
    end
  end

  always_comb begin
    word_sh  = rd_word_q >> {lane_q, 3'b000};
    half_sel = lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    case (op_q)
      3'b000:  load_ext = {{24{word_sh[7]}}, word_sh[7:0]};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'h000000, word_sh[7:0]};
      3'b101:  load_ext = {16'h0000, half_sel};
      default: load_ext = rd_word_q;
    endcase
    rsp_valid = (state_q == RESP);
    rsp_err   = rsp_valid & err_q;
    DataOut   = (rsp_valid && !err_q && !we_q) ? load_ext : 32'h0;
  end

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: stores, extending loads, errors, back-to-back and reset.
module tb_data_mem;

  localparam int unsigned DEPTH = 1024;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  MemOp;
  logic [31:0] Addr;
  logic [31:0] DataIn;
  logic        rsp_valid;
  logic [31:0] DataOut;
  logic        rsp_err;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  data_mem #(.DEPTH_WORDS(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .MemOp(MemOp), .Addr(Addr), .DataIn(DataIn),
    .rsp_valid(rsp_valid), .DataOut(DataOut), .rsp_err(rsp_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One request: present at negedge, accept at next posedge, check the response cycle.
  task automatic xact(input string tag, input logic we, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_data, input logic exp_err);
    int unsigned budget;
    @(negedge Clk);
    budget = 0;
    while (!req_ready && budget < 10) begin
      @(negedge Clk);
      budget++;
    end
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; MemOp = op; Addr = a; DataIn = d;
    @(posedge Clk);
    #1 req_valid = 1'b0;
    @(negedge Clk);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_data"}, DataOut, exp_data);
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    chk({tag, "_busy"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    int unsigned pulses;
    Rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; MemOp = 3'b010;
    Addr = 32'h0; DataIn = 32'h0;
    #1;
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_err", 32'(rsp_err), 32'd0);
    chk("reset_data", DataOut, 32'h0);
    repeat (2) @(negedge Clk);
    Rst = 1'b0;

    xact("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    xact("sb11", 1'b1, 3'b000, 32'h11, 32'h000000A5, 32'h0, 1'b0);
    xact("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADA5EF, 1'b0);
    xact("lb11", 1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFA5, 1'b0);
    xact("lbu11", 1'b0, 3'b100, 32'h11, 32'h0, 32'h000000A5, 1'b0);
    xact("lh12", 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
    xact("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);
    xact("lhu10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000A5EF, 1'b0);

    xact("lw13_mis", 1'b0, 3'b010, 32'h13, 32'h0, 32'h0, 1'b1);
    xact("sh11_mis", 1'b1, 3'b001, 32'h11, 32'h1234, 32'h0, 1'b1);
    xact("lw10_kept", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADA5EF, 1'b0);
    xact("op011_rsv", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    xact("sbu_rsv", 1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1);
    xact("lw_oor", 1'b0, 3'b010, 32'(4 * DEPTH), 32'h0, 32'h0, 1'b1);
    xact("lw10_kept2", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADA5EF, 1'b0);

    // Back-to-back: hold req_valid high and watch the 1/0 handshake rhythm.
    @(negedge Clk);
    req_valid = 1'b1; req_we = 1'b0; MemOp = 3'b010; Addr = 32'h10;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge Clk);
      chk($sformatf("b2b_ready%0d", k), 32'(req_ready), 32'((k % 2) == 0));
      chk($sformatf("b2b_rsp%0d", k), 32'(rsp_valid), 32'((k % 2) == 1));
      if (rsp_valid) begin
        pulses++;
        chk($sformatf("b2b_data%0d", k), DataOut, 32'hDEADA5EF);
      end
    end
    req_valid = 1'b0;
    chk("b2b_pulses", pulses, 32'd4);

    // Reset in the response cycle of a load drops the response.
    xact("lw_pre_rst", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADA5EF, 1'b0);
    Rst = 1'b1;
    #1;
    chk("rst_rsp_drop", 32'(rsp_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_data", DataOut, 32'h0);
    @(negedge Clk);
    Rst = 1'b0;
    pulses = 0;
    repeat (3) begin
      @(negedge Clk);
      if (rsp_valid) pulses++;
    end
    chk("rst_no_late_rsp", pulses, 32'd0);

    // Stored data survives a reset.
    xact("sw20", 1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    xact("lw20_after_rst", 1'b0, 3'b010, 32'h20, 32'h0, 32'h11223344, 1'b0);

    @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
